// File: rtl/mul_share_ctrl_if.sv
// Bus between the sharing controller and the single sequential Booth multiplier.
// master = controller side, slave = multiplier side.
interface mul_share_ctrl_if #(
    parameter int N = 16
);
    logic [N-1:0]   mul_M;
    logic [N-1:0]   mul_R;
    logic           mul_enable;
    logic           mul_reset;
    logic           mul_finish;
    logic [2*N-1:0] mul_result;

    modport master (
        output mul_M, mul_R, mul_enable, mul_reset,
        input  mul_finish, mul_result
    );

    modport slave (
        input  mul_M, mul_R, mul_enable, mul_reset,
        output mul_finish, mul_result
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin time-sharing of one sequential Booth multiplier among NREQ requesters,
// with fixed-point rescaling. Optional macro MUL_SHARE_SAT_EN clamps the scaled result.
module mul_share_ctrl #(
    parameter  int N    = 16,
    parameter  int FRAC = 10,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] opa_flat,
    input  logic [NREQ*N-1:0] opb_flat,
    output logic [NREQ-1:0]   done,
    output logic [N-1:0]      result,
    output logic [2*N-1:0]    result_raw,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    mul_share_ctrl_if.master  mbus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t         state_r;
    logic [IDW-1:0] rr_r;
    logic [IDW:0]   pick_s;
    logic           pick_valid_s;
    logic [IDW-1:0] pick_id_s;

    // Returns {found, index} of the first set request at or above ptr, wrapping around.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] ptr);
        logic           found;
        logic [IDW-1:0] idx;
        int             k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr) + i) % NREQ;
            if (!found && r[k]) begin
                found = 1'b1;
                idx   = k[IDW-1:0];
            end
        end
        return {found, idx};
    endfunction

    // Arithmetic shift by FRAC (floor), then wrap or clamp into N signed bits.
    function automatic logic [N-1:0] scale(input logic [2*N-1:0] p);
        logic [2*N-1:0] sh;
        sh = $signed(p) >>> FRAC;
`ifdef MUL_SHARE_SAT_EN
        if ((sh[2*N-1:N-1] == {(N+1){1'b0}}) || (sh[2*N-1:N-1] == {(N+1){1'b1}})) begin
            return sh[N-1:0];
        end else if (sh[2*N-1]) begin
            return {1'b1, {(N-1){1'b0}}};
        end else begin
            return {1'b0, {(N-1){1'b1}}};
        end
`else
        return sh[N-1:0];
`endif
    endfunction

    // Round-robin candidate for the next grant.
    always_comb begin
        pick_s       = rr_pick(req, rr_r);
        pick_valid_s = pick_s[IDW];
        pick_id_s    = pick_s[IDW-1:0];
    end

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= IDLE;
            rr_r            <= '0;
            done            <= '0;
            result          <= '0;
            result_raw      <= '0;
            grant_id        <= '0;
            busy            <= 1'b0;
            mbus.mul_M      <= '0;
            mbus.mul_R      <= '0;
            mbus.mul_enable <= 1'b0;
            mbus.mul_reset  <= 1'b0;
        end else begin
            done <= '0;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_id        <= pick_id_s;
                        mbus.mul_M      <= opa_flat[pick_id_s*N +: N];
                        mbus.mul_R      <= opb_flat[pick_id_s*N +: N];
                        mbus.mul_enable <= 1'b1;
                        mbus.mul_reset  <= 1'b1;
                        busy            <= 1'b1;
                        state_r         <= LOAD;
                    end else begin
                        mbus.mul_enable <= 1'b0;
                        mbus.mul_reset  <= 1'b0;
                        busy            <= 1'b0;
                    end
                end
                LOAD: begin
                    mbus.mul_reset <= 1'b0;
                    state_r        <= RUN;
                end
                RUN: begin
                    if (mbus.mul_finish) begin
                        result_raw      <= mbus.mul_result;
                        result          <= scale(mbus.mul_result);
                        done            <= {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
                        rr_r            <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                        mbus.mul_enable <= 1'b0;
                        busy            <= 1'b0;
                        state_r         <= IDLE;
                    end else begin
                        mbus.mul_enable <= 1'b1;
                    end
                end
                default: begin
                    mbus.mul_enable <= 1'b0;
                    mbus.mul_reset  <= 1'b0;
                    busy            <= 1'b0;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed self-checking bench for mul_share_ctrl with a behavioural Booth multiplier
// (product latched on load, finish after N+1 run cycles).
module tb_mul_share_ctrl;

    localparam int N    = 16;
    localparam int NREQ = 4;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] opa_flat;
    logic [NREQ*N-1:0] opb_flat;
    logic [NREQ-1:0]   done;
    logic [N-1:0]      result;
    logic [2*N-1:0]    result_raw;
    logic [1:0]        grant_id;
    logic              busy;

    int checks = 0;
    int errors = 0;

    mul_share_ctrl_if #(.N(N)) mbus ();

    mul_share_ctrl #(.N(N), .FRAC(10), .NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .opa_flat   (opa_flat),
        .opb_flat   (opb_flat),
        .done       (done),
        .result     (result),
        .result_raw (result_raw),
        .grant_id   (grant_id),
        .busy       (busy),
        .mbus       (mbus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model
    logic [4:0]  mcnt  = 5'd0;
    logic [31:0] mprod = 32'd0;
    always @(posedge clk) begin
        if (mbus.mul_enable) begin
            if (mbus.mul_reset) begin
                mcnt  <= 5'd0;
                mprod <= $signed(mbus.mul_M) * $signed(mbus.mul_R);
            end else if (mcnt != 5'd17) begin
                mcnt <= mcnt + 5'd1;
            end
        end
    end
    assign mbus.mul_finish = (mcnt == 5'd17);
    assign mbus.mul_result = mprod;

    task automatic wait_done(output int edges, output logic [3:0] d);
        edges = -1;
        d     = 4'd0;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk); #1;
            if (done != 4'd0) begin
                edges = e;
                d     = done;
                return;
            end
        end
    endtask

    task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b);
        opa_flat[id*N +: N] = a;
        opb_flat[id*N +: N] = b;
    endtask

    task automatic test_reset;
        reset = 1'b0; req = 4'd0; opa_flat = '0; opb_flat = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({done, result, result_raw, grant_id, busy} !== 55'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {done, result, result_raw, grant_id, busy});
        end
        checks++;
        if ({mbus.mul_M, mbus.mul_R, mbus.mul_enable, mbus.mul_reset} !== 34'd0) begin
            errors++; $display("FAIL reset_mulbus: got %h want 0", {mbus.mul_M, mbus.mul_R, mbus.mul_enable, mbus.mul_reset});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int e; logic [3:0] d;
        set_ops(0, 16'h0600, 16'h0800);
        req = 4'b0001;
        wait_done(e, d);
        req = 4'b0000;
        checks++; if (e !== 19) begin errors++; $display("FAIL basic_latency: got %0d want 19", e); end
        checks++; if (d !== 4'b0001) begin errors++; $display("FAIL basic_done: got %b want 0001", d); end
        checks++; if (result !== 16'h0C00) begin errors++; $display("FAIL basic_result: got %h want 0c00", result); end
        checks++; if (result_raw !== 32'h00300000) begin errors++; $display("FAIL basic_raw: got %h want 00300000", result_raw); end
        @(posedge clk); #1;
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL basic_pulse: got %b want 0000", done); end
        checks++; if (result !== 16'h0C00 || busy !== 1'b0) begin errors++; $display("FAIL basic_hold: got %h/%b want 0c00/0", result, busy); end
    endtask

    task automatic test_negative;
        int e; logic [3:0] d;
        @(negedge clk);
        set_ops(1, 16'hFA00, 16'h0800);
        req = 4'b0010;
        wait_done(e, d);
        req = 4'b0000;
        checks++; if (d !== 4'b0010) begin errors++; $display("FAIL neg_done: got %b want 0010", d); end
        checks++; if (result !== 16'hF400) begin errors++; $display("FAIL neg_result: got %h want f400", result); end
        checks++; if (result_raw !== 32'hFFD00000) begin errors++; $display("FAIL neg_raw: got %h want ffd00000", result_raw); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL neg_grant: got %0d want 1", grant_id); end
    endtask

    task automatic test_overflow;
        int e; logic [3:0] d;
        logic [15:0] exp_r;
`ifdef MUL_SHARE_SAT_EN
        exp_r = 16'h7FFF;
`else
        exp_r = 16'h1000;
`endif
        @(negedge clk);
        set_ops(0, 16'h7800, 16'h7800);
        req = 4'b0001;
        wait_done(e, d);
        req = 4'b0000;
        checks++; if (result !== exp_r) begin errors++; $display("FAIL ovf_result: got %h want %h", result, exp_r); end
        checks++; if (result_raw !== 32'h38400000) begin errors++; $display("FAIL ovf_raw: got %h want 38400000", result_raw); end
    endtask

    task automatic test_trunc;
        int e; logic [3:0] d;
        @(negedge clk);
        set_ops(3, 16'hFFFF, 16'h0001);
        req = 4'b1000;
        wait_done(e, d);
        req = 4'b0000;
        checks++; if (d !== 4'b1000) begin errors++; $display("FAIL trunc_done: got %b want 1000", d); end
        checks++; if (result !== 16'hFFFF || result_raw !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL trunc_result: got %h/%h want ffff/ffffffff", result, result_raw);
        end
    endtask

    task automatic test_operand_change;
        int e; logic [3:0] d;
        @(negedge clk);
        set_ops(2, 16'h0200, 16'h0C00);
        req = 4'b0100;
        @(posedge clk); #1;
        checks++;
        if ({busy, mbus.mul_enable, mbus.mul_reset} !== 3'b111 || mbus.mul_M !== 16'h0200 || grant_id !== 2'd2) begin
            errors++; $display("FAIL load_state: got %b M=%h g=%0d want 111 M=0200 g=2",
                               {busy, mbus.mul_enable, mbus.mul_reset}, mbus.mul_M, grant_id);
        end
        set_ops(2, 16'h7FFF, 16'h7FFF);
        @(posedge clk); #1;
        checks++;
        if ({busy, mbus.mul_enable, mbus.mul_reset} !== 3'b110 || mbus.mul_R !== 16'h0C00) begin
            errors++; $display("FAIL run_state: got %b R=%h want 110 R=0c00", {busy, mbus.mul_enable, mbus.mul_reset}, mbus.mul_R);
        end
        wait_done(e, d);
        req = 4'b0000;
        checks++; if (result !== 16'h0600) begin errors++; $display("FAIL opchange_result: got %h want 0600", result); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int t[5];
        logic [3:0] ds[5];
        reset = 1'b0;
        for (int k = 0; k < NREQ; k++) set_ops(k, 16'h0400, 16'h0400);
        req = 4'b1111;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 200 && n < 5; c++) begin
            @(posedge clk); #1;
            if (done != 4'd0) begin
                t[n] = c; ds[n] = done; n++;
                if (n == 5) req = 4'b0000;
            end
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL rr_count: got %0d want 5", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (ds[i] !== (4'b0001 << (i % 4))) begin
                errors++; $display("FAIL rr_order%0d: got %b want %b", i, ds[i], 4'b0001 << (i % 4));
            end
            if (i > 0) begin
                checks++;
                if (t[i] - t[i-1] !== 20) begin errors++; $display("FAIL rr_spacing%0d: got %0d want 20", i, t[i] - t[i-1]); end
            end
        end
    endtask

    task automatic test_rr_preempt;
        int e; logic [3:0] d;
        @(negedge clk);
        set_ops(0, 16'h0400, 16'h0800);
        set_ops(2, 16'h0800, 16'h0800);
        req = 4'b0001;
        repeat (4) @(posedge clk);
        #1 req = 4'b0101;
        wait_done(e, d);
        checks++; if (d !== 4'b0001) begin errors++; $display("FAIL pre_first: got %b want 0001", d); end
        @(posedge clk); #1;
        checks++; if (grant_id !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL pre_grant: got %0d/%b want 2/1", grant_id, busy); end
        wait_done(e, d);
        req = 4'b0000;
        checks++; if (d !== 4'b0100 || result !== 16'h1000) begin errors++; $display("FAIL pre_second: got %b/%h want 0100/1000", d, result); end
    endtask

    task automatic test_reset_mid_run;
        int e; int spurious = 0; logic [3:0] d;
        @(negedge clk);
        set_ops(0, 16'h0400, 16'hFC00);
        req = 4'b0001;
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({done, result, result_raw, grant_id, busy, mbus.mul_M, mbus.mul_R, mbus.mul_enable, mbus.mul_reset} !== 89'd0) begin
            errors++; $display("FAIL midrst_outputs: got %h want 0",
                               {done, result, result_raw, grant_id, busy, mbus.mul_M, mbus.mul_R, mbus.mul_enable, mbus.mul_reset});
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done != 4'd0) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL midrst_done: got %0d pulses want 0", spurious); end
        @(negedge clk);
        reset = 1'b1;
        wait_done(e, d);
        req = 4'b0000;
        checks++; if (e !== 19 || d !== 4'b0001) begin errors++; $display("FAIL midrst_resume: got %0d/%b want 19/0001", e, d); end
        checks++; if (result !== 16'hFC00 || result_raw !== 32'hFFF00000) begin
            errors++; $display("FAIL midrst_result: got %h/%h want fc00/fff00000", result, result_raw);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_overflow();
        test_trunc();
        test_operand_change();
        test_back_to_back();
        test_rr_preempt();
        test_reset_mid_run();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
